// File: rtl/demux_sipo8_pkg.sv
// rtl/demux_sipo8_pkg.sv - shared constants for the serial-to-parallel demux
package demux_sipo8_pkg;

    localparam int   N_DEFAULT     = 8;
    localparam int   SEL_W_DEFAULT = $clog2(N_DEFAULT);
    localparam logic Y_RESET_BIT   = 1'b0;

endpackage

// File: rtl/demux_sipo8_decoder3to8.sv
// rtl/demux_sipo8_decoder3to8.sv - enable-gated one-hot select decoder
module decoder3to8 #(
    parameter int SEL_W = 3,
    parameter int N     = 1 << SEL_W
) (
    input  logic [SEL_W-1:0] sel_i,
    input  logic             en_i,
    output logic [N-1:0]     onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_sipo8.sv
// rtl/demux_sipo8.sv - 1-to-8 serial demux assembling bits into a parallel word
module demux_sipo8
    import demux_sipo8_pkg::*;
#(
    parameter int   N     = N_DEFAULT,
    localparam int  SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             En,
    input  logic             clr,
    input  logic             d,
    output logic [SEL_W-1:0] W,
    output logic [0:N-1]     Y,
    output logic             valid,
    output logic             busy
);

    logic [SEL_W-1:0] w_q, w_d;
    logic [0:N-1]     s_q, s_d;
    logic [0:N-1]     y_q, y_d;
    logic             valid_q, valid_d;
    logic [N-1:0]     bit_we;
    logic [0:N-1]     s_wr;
    logic             last_pos;

    decoder3to8 #(
        .SEL_W (SEL_W),
        .N     (N)
    ) u_dec (
        .sel_i    (w_q),
        .en_i     (En & ~clr),
        .onehot_o (bit_we)
    );

    assign last_pos = (w_q == SEL_W'(N - 1));

    always_comb begin
        s_wr = s_q;
        for (int i = 0; i < N; i++) begin
            if (bit_we[i]) begin
                s_wr[i] = d;
            end
        end
    end

    always_comb begin
        w_d     = w_q;
        s_d     = s_q;
        y_d     = y_q;
        valid_d = 1'b0;
        if (clr) begin
            w_d = '0;
            s_d = '0;
        end else if (En) begin
            if (last_pos) begin
                // Final bit goes straight into Y alongside the shadow bits
                y_d     = s_wr;
                s_d     = '0;
                w_d     = '0;
                valid_d = 1'b1;
            end else begin
                s_d = s_wr;
                w_d = w_q + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q     <= '0;
            s_q     <= '0;
            y_q     <= {N{Y_RESET_BIT}};
            valid_q <= 1'b0;
        end else begin
            w_q     <= w_d;
            s_q     <= s_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign W     = w_q;
    assign Y     = y_q;
    assign valid = valid_q;
    assign busy  = (w_q != '0);

endmodule
